// File: rtl/btn_evt_pkg.sv
// Shared types and defaults for the button event decoder.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package btn_evt_pkg;

  localparam int CNT_W = 32;

  localparam logic [CNT_W-1:0] DEF_LONG_CYCLES   = 32'd25_000_000;
  localparam logic [CNT_W-1:0] DEF_REPEAT_CYCLES = 32'd5_000_000;
  localparam logic [CNT_W-1:0] DEF_DCLICK_CYCLES = 32'd12_500_000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HELD  = 3'd1,
    S_LONG  = 3'd2,
    S_ARMED = 3'd3,
    S_HELD2 = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Registers the previous button level and derives rise/fall strobes.
// Latency: level is btn delayed one cycle; rise/fall are combinational against it.
// Backpressure: none; a new sample is taken every cycle.
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  // Previous-cycle sample of the button; zero after reset so a held button
  // produces a rise on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level <= 1'b0;
    else        level <= btn;
  end

  assign rise = btn & ~level;
  assign fall = ~btn & level;

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat/double-click pulses.
// Latency: every output is registered, one cycle after the deciding clock edge.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [CNT_W-1:0] DCLICK_CYCLES = DEF_DCLICK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic held,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click
);

  logic             rise;
  logic             fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             long_nxt, rep_nxt, dclick_nxt;

  btn_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .level (held),
    .rise  (rise),
    .fall  (fall)
  );

  // Next-state and pulse decode. cnt counts edges spent in the current state
  // (value k-1 at the k-th edge after entry), so thresholds compare to X-1.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = sat_inc(cnt);
    long_nxt   = 1'b0;
    rep_nxt    = 1'b0;
    dclick_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (rise) state_nxt = S_HELD;
      end
      S_HELD, S_HELD2: begin
        // A fall on the threshold edge wins over the long-press.
        if (fall) begin
          state_nxt = (state == S_HELD) ? S_ARMED : S_IDLE;
        end else if (cnt == LONG_CYCLES - 1'b1) begin
          state_nxt = S_LONG;
          long_nxt  = 1'b1;
        end
      end
      S_LONG: begin
        // Long presses never arm a double click, so release goes to IDLE.
        if (fall) begin
          state_nxt = S_IDLE;
        end else if (cnt == REPEAT_CYCLES - 1'b1) begin
          rep_nxt = 1'b1;
          cnt_nxt = '0;
        end
      end
      S_ARMED: begin
        // The rise is tested before the timeout so a rise on the last
        // allowed edge still counts as a double click.
        if (rise) begin
          state_nxt  = S_HELD2;
          dclick_nxt = 1'b1;
        end else if (cnt == DCLICK_CYCLES - 1'b1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press         <= rise;
      release_pulse <= fall;
      long_press    <= long_nxt;
      repeat_pulse  <= rep_nxt;
      double_click  <= dclick_nxt;
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder against an edge-indexed reference model.
// Latency: outputs are sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_btn_event_decoder;

  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic held, press, release_pulse, long_press, repeat_pulse, double_click;

  int vectors = 0;
  int miscompares = 0;

  // Model state: edge counter, previous sample, start edge of the current
  // press, whether that press was the second of a double click, and the
  // edge of the last release that may still arm a double click.
  int edge_n;
  bit m_prev;
  int m_start;
  bit m_second;
  bit m_armed;
  int m_rel;

  bit pat[$];

  btn_event_decoder #(
    .LONG_CYCLES   (32'd8),
    .REPEAT_CYCLES (32'd4),
    .DCLICK_CYCLES (32'd5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .held          (held),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .double_click  (double_click)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {held, press, release_pulse, long_press, repeat_pulse, double_click};
  endfunction

  task automatic model_reset();
    edge_n   = 0;
    m_prev   = 1'b0;
    m_start  = 0;
    m_second = 1'b0;
    m_armed  = 1'b0;
    m_rel    = 0;
  endtask

  // Expected {held,press,release,long,repeat,dclick} for the edge sampling b.
  task automatic model_step(input bit b, output logic [5:0] e);
    bit rise, fall, lp, rp, dc;
    int age;
    rise = b && !m_prev;
    fall = !b && m_prev;
    lp = 1'b0; rp = 1'b0; dc = 1'b0;
    edge_n++;
    if (rise) begin
      dc       = m_armed && (edge_n - m_rel <= D);
      m_second = dc;
      m_start  = edge_n;
      m_armed  = 1'b0;
    end
    if (b) begin
      age = edge_n - m_start;
      lp  = (age == L);
      rp  = (age > L) && ((age - L) % R == 0);
    end
    if (fall) begin
      age = edge_n - m_start;
      // age > L means the button was still down on the threshold edge.
      if (age <= L && !m_second) begin
        m_armed = 1'b1;
        m_rel   = edge_n;
      end else begin
        m_armed = 1'b0;
      end
    end
    m_prev = b;
    e = {b, rise, fall, lp, rp, dc};
  endtask

  task automatic apply(input bit b, output logic [5:0] e, output logic [5:0] a);
    @(negedge clk);
    btn = b;
    model_step(b, e);
    @(posedge clk);
    #1;
    a = outs();
  endtask

  task automatic add_run(input bit v, input int n);
    for (int i = 0; i < n; i++) pat.push_back(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (outs() !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", outs(), 6'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_short_press();
    logic [5:0] e, a;
    int p = -1, rl = -1, nlong = 0;
    pat = {};
    add_run(0, 2); add_run(1, 3); add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL short_press step %0d: got %b want %b", i, a, e);
      end
      if (a[4] && p < 0) p = i;
      if (a[3] && rl < 0) rl = i;
      if (a[2]) nlong++;
    end
    vectors++;
    if (rl - p !== 3 || nlong !== 0) begin
      miscompares++;
      $display("FAIL short_press_timing: gap %0d longs %0d want gap 3 longs 0", rl - p, nlong);
    end
  endtask

  task automatic test_long_hold();
    logic [5:0] e, a;
    int p = -1, lp = -1, rl = -1, ndc = 0;
    int reps[$];
    pat = {};
    add_run(0, 2); add_run(1, 20); add_run(0, 2); add_run(1, 3); add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL long_hold step %0d: got %b want %b", i, a, e);
      end
      if (a[4] && p < 0) p = i;
      if (a[2] && lp < 0) lp = i;
      if (a[1]) reps.push_back(i - p);
      if (a[3] && rl < 0) rl = i;
      if (a[0]) ndc++;
    end
    vectors++;
    if (lp - p !== 8 || rl - p !== 20) begin
      miscompares++;
      $display("FAIL long_hold_timing: long +%0d release +%0d want +8 +20", lp - p, rl - p);
    end
    vectors++;
    if (reps.size() !== 2 || reps[0] !== 12 || reps[1] !== 16) begin
      miscompares++;
      $display("FAIL long_hold_repeats: got %p want 12,16", reps);
    end
    vectors++;
    if (ndc !== 0) begin
      miscompares++;
      $display("FAIL long_hold_no_dclick: got %0d double clicks want 0", ndc);
    end
  endtask

  task automatic test_double_click();
    logic [5:0] e, a;
    int ndc = 0, lone = 0;
    pat = {};
    add_run(0, 2); add_run(1, 2); add_run(0, 5); add_run(1, 2);
    add_run(0, 5); add_run(1, 2); add_run(0, 8);
    add_run(1, 2); add_run(0, 6); add_run(1, 2); add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL double_click step %0d: got %b want %b", i, a, e);
      end
      if (a[0]) ndc++;
      if (a[0] && !a[4]) lone++;
    end
    vectors++;
    if (ndc !== 1 || lone !== 0) begin
      miscompares++;
      $display("FAIL double_click_count: got %0d (unpaired %0d) want 1 (unpaired 0)", ndc, lone);
    end
  endtask

  task automatic test_boundary();
    logic [5:0] e, a;
    int presses[$];
    int lp = -1, nlong = 0;
    pat = {};
    add_run(0, 8); add_run(1, 8); add_run(0, 8); add_run(1, 9); add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL boundary step %0d: got %b want %b", i, a, e);
      end
      if (a[4]) presses.push_back(i);
      if (a[2]) begin nlong++; lp = i; end
    end
    vectors++;
    if (nlong !== 1 || presses.size() !== 2 || lp - presses[1] !== 8) begin
      miscompares++;
      $display("FAIL boundary_long: longs %0d at +%0d want 1 at +8", nlong, lp - presses[presses.size()-1]);
    end
  endtask

  task automatic test_reset_mid_long();
    logic [5:0] e, a;
    int p = -1, lp = -1;
    pat = {};
    add_run(0, 1); add_run(1, 12);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL pre_reset step %0d: got %b want %b", i, a, e);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_async: got %b want %b", outs(), 6'b0);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (outs() !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", c, outs(), 6'b0);
      end
    end
    model_reset();
    rst_n = 1'b1;
    pat = {};
    add_run(1, 12); add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL post_reset step %0d: got %b want %b", i, a, e);
      end
      if (a[4] && p < 0) p = i;
      if (a[2] && lp < 0) lp = i;
    end
    vectors++;
    if (p !== 0 || lp !== 8) begin
      miscompares++;
      $display("FAIL post_reset_timing: press at %0d long at %0d want 0 and 8", p, lp);
    end
  endtask

  task automatic test_random();
    logic [5:0] e, a;
    bit lvl = 1'b0;
    pat = {};
    for (int r = 0; r < 60; r++) begin
      add_run(lvl, $urandom_range(1, 12));
      lvl = ~lvl;
    end
    add_run(0, 8);
    foreach (pat[i]) begin
      apply(pat[i], e, a);
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL random step %0d: got %b want %b", i, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_hold();
    test_double_click();
    test_boundary();
    test_reset_mid_long();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
REQ-001 LONG_CYCLES, 25_000_000, cycles a press must be held before long_press fires; legal range 2..2^32-1.
REQ-002 REPEAT_CYCLES, 5_000_000, cycles between repeat pulses after long_press; legal range 1..2^32-1.
REQ-003 DCLICK_CYCLES, 12_500_000, maximum release-to-press gap for a double click; legal range 1..2^32-1.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn  input  1  already-debounced button level, 1 = pressed.
REQ-007 held  output  1  registered copy of btn, one-cycle delay.
REQ-008 press  output  1  one-cycle pulse on each press.
REQ-009 release  output  1  one-cycle pulse on each release.
REQ-010 long_press  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-011 repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while still held.
REQ-012 double_click  output  1  one-cycle pulse on the second press of a double click.

Function
REQ-013 All outputs SHALL be registered; no combinational path from btn to any output.
REQ-014 Edge definitions: rise at edge N = btn sampled 1 at N and 0 at N-1; fall = the inverse.
REQ-015 press SHALL be high for exactly the cycle following edge N on a rise; release likewise on a fall.
REQ-016 FSM states: IDLE, HELD, LONG, ARMED, HELD2. One 32-bit counter cnt, cleared on every state change.
REQ-017 IDLE: rise -> HELD.
REQ-018 HELD: fall -> ARMED. If btn is sampled 1 at every edge N..N+LONG_CYCLES, then at edge N+LONG_CYCLES -> LONG with a long_press pulse.
REQ-019 LONG: repeat_pulse at edges N+LONG_CYCLES+k*REPEAT_CYCLES, k>=1, while held. Fall -> IDLE. Long presses SHALL NOT arm a double click.
REQ-020 ARMED: for a release at edge R, a rise at edge R+k with 1<=k<=DCLICK_CYCLES -> HELD2, with press and double_click pulsed in the same cycle. No rise by edge R+DCLICK_CYCLES -> IDLE. A rise coinciding with the timeout edge counts as a double click.
REQ-021 HELD2: same long-press timing as HELD (-> LONG); fall -> IDLE (no re-arm, so a third press is a single press).
REQ-022 Fall and long-threshold on the same edge: fall wins; no long_press; HELD -> ARMED.
REQ-023 cnt SHALL saturate at 2^32-1 and never wrap.
REQ-024 At most one of long_press / repeat_pulse asserts per cycle; press and release never assert together.

Reset
REQ-025 rst_n low: held, press, release, long_press, repeat_pulse, double_click = 0; FSM = IDLE; cnt = 0; sampled-previous btn = 0.
REQ-026 Reset takes effect immediately, including mid-press or mid-ARMED. If btn = 1 at the first edge after deassertion, that edge is a rise and press pulses.

Structure
REQ-027 Package btn_evt_pkg SHALL hold the FSM state enum, the 32-bit counter width constant and the default parameter values.
REQ-028 Sub-module btn_edge_det (registered previous level, rise/fall strobes) SHALL be instantiated once. The FSM and counter reside in btn_event_decoder.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4, DCLICK_CYCLES=5)
REQ-029 Short press: btn high for 3 cycles -> one press and one release, 3 cycles apart; no long_press; FSM ends in ARMED, then IDLE 5 cycles after release.
REQ-030 Long hold: btn high for 20 cycles -> press at t0, long_press at t0+8, repeat_pulse at t0+12 and t0+16, release at t0+20; no double_click on a re-press 2 cycles later.
REQ-031 Double click: press 2 cycles, low 5 cycles, press again -> second press coincides with double_click. A gap of 6 cycles -> no double_click. A third quick press -> no double_click.
REQ-032 Boundary: btn high exactly 8 cycles (fall on the threshold edge) -> no long_press.
REQ-033 Reset mid-LONG: assert rst_n for 2 cycles while btn=1 -> all outputs 0 during reset; after deassertion, a press pulse on the first edge, and long_press 8 cycles later.
